// File: rtl/csr_rmw_if.sv
// Request/response and CSR-file signals of the CSR read-modify-write unit.
// The slave modport is the unit; the master modport is the requester plus CSR file.
interface csr_rmw_if;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] csr_index;
  logic [4:0]  rs1_field;
  logic [31:0] rs1_data;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] rd_data;
  logic [31:0] csr_read_data;
  logic        read_enable_csr;
  logic [11:0] csr_read_index;
  logic        write_enable_csr;
  logic [11:0] csr_write_index;
  logic [31:0] csr_write_data;

  modport slave (
    input  start, funct3, csr_index, rs1_field, rs1_data, csr_read_data,
    output busy, done, illegal, rd_data,
           read_enable_csr, csr_read_index,
           write_enable_csr, csr_write_index, csr_write_data
  );

  modport master (
    output start, funct3, csr_index, rs1_field, rs1_data, csr_read_data,
    input  busy, done, illegal, rd_data,
           read_enable_csr, csr_read_index,
           write_enable_csr, csr_write_index, csr_write_data
  );
endinterface

// File: rtl/csr_rmw.sv
// CSR read-modify-write sequencer: IDLE -> READ -> (WRITE) -> DONE, all outputs registered.
// Strobes are flops, so an asynchronous reset drops write_enable_csr before the file's falling-edge commit.
module csr_rmw_unit (
  input  logic     CLK,
  input  logic     reset,
  csr_rmw_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [11:0] idx_q;
  logic [4:0]  rs1f_q;
  logic [31:0] rs1d_q;
  logic [31:0] old_q;

  logic        req_illegal;
  logic        suppress;
  logic [31:0] src;
  logic [31:0] wval;

  // funct3[1:0]==00 covers both reserved opcodes 000 and 100
  always_comb begin
    req_illegal = (bus.funct3[1:0] == 2'b00) ||
                  !(bus.csr_index inside {12'h800, 12'h801, 12'h802});
    suppress    = (f3_q[1:0] != 2'b01) && (rs1f_q == 5'd0);
    src         = f3_q[2] ? {27'b0, rs1f_q} : rs1d_q;
    case (f3_q[1:0])
      2'b01:   wval = src;
      2'b10:   wval = bus.csr_read_data | src;
      default: wval = bus.csr_read_data & ~src;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      f3_q                 <= '0;
      idx_q                <= '0;
      rs1f_q               <= '0;
      rs1d_q               <= '0;
      old_q                <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.illegal          <= 1'b0;
      bus.rd_data          <= '0;
      bus.read_enable_csr  <= 1'b0;
      bus.csr_read_index   <= '0;
      bus.write_enable_csr <= 1'b0;
      bus.csr_write_index  <= '0;
      bus.csr_write_data   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          f3_q     <= bus.funct3;
          idx_q    <= bus.csr_index;
          rs1f_q   <= bus.rs1_field;
          rs1d_q   <= bus.rs1_data;
          bus.busy <= 1'b1;
          if (req_illegal) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.illegal <= 1'b1;
            bus.rd_data <= '0;
          end else begin
            state                <= READ;
            bus.read_enable_csr  <= 1'b1;
            bus.csr_read_index   <= bus.csr_index;
          end
        end
        READ: begin
          old_q               <= bus.csr_read_data;
          bus.read_enable_csr <= 1'b0;
          bus.csr_read_index  <= '0;
          if (suppress) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.rd_data <= bus.csr_read_data;
          end else begin
            state                <= WRITE;
            bus.write_enable_csr <= 1'b1;
            bus.csr_write_index  <= idx_q;
            bus.csr_write_data   <= wval;
          end
        end
        WRITE: begin
          state                <= DONE;
          bus.write_enable_csr <= 1'b0;
          bus.csr_write_index  <= '0;
          bus.csr_write_data   <= '0;
          bus.done             <= 1'b1;
          bus.rd_data          <= old_q;
        end
        DONE: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          bus.illegal <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed bench for csr_rmw_unit with a three-register CSR file model
// (combinational read, commit on falling CLK edge).
module tb_csr_rmw_unit;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  csr_rmw_if bus ();
  csr_rmw_unit dut (.CLK(CLK), .reset(reset), .bus(bus));

  logic [31:0] alu_csr, mul_csr, div_csr;
  int we_cnt = 0, re_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  int passes = 0, total = 0;

  always_comb begin
    bus.csr_read_data = 32'h0;
    if (bus.read_enable_csr)
      case (bus.csr_read_index)
        12'h800: bus.csr_read_data = alu_csr;
        12'h801: bus.csr_read_data = mul_csr;
        12'h802: bus.csr_read_data = div_csr;
        default: bus.csr_read_data = 32'h0;
      endcase
  end

  always @(negedge CLK) begin
    if (bus.write_enable_csr) begin
      we_cnt++;
      case (bus.csr_write_index)
        12'h800: alu_csr = bus.csr_write_data;
        12'h801: mul_csr = bus.csr_write_data;
        12'h802: div_csr = bus.csr_write_data;
        default: ;
      endcase
    end
    if (bus.read_enable_csr) re_cnt++;
    if (bus.done) done_cnt++;
    if (bus.read_enable_csr && bus.write_enable_csr) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Drive a request so that the next rising edge accepts it; returns #1 after that edge.
  task automatic issue(input logic [2:0] f3, input logic [11:0] idx,
                       input logic [4:0] rs1f, input logic [31:0] rs1d);
    bus.start = 1'b1; bus.funct3 = f3; bus.csr_index = idx;
    bus.rs1_field = rs1f; bus.rs1_data = rs1d;
    step();
    bus.start = 1'b0;
  endtask

  int we0, re0, d0;

  initial begin
    alu_csr = 32'h0000_00F0; mul_csr = 32'h0000_00AA; div_csr = 32'h0000_0055;
    bus.start = 1'b0; bus.funct3 = 3'b0; bus.csr_index = 12'h0;
    bus.rs1_field = 5'h0; bus.rs1_data = 32'h0;
    #12;
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_rd", bus.rd_data, 32'h0);
    chk("rst_re", {31'b0, bus.read_enable_csr}, 32'h0);
    chk("rst_we", {31'b0, bus.write_enable_csr}, 32'h0);
    chk("rst_wdata", bus.csr_write_data, 32'h0);
    reset = 1'b1;

    // RW 0x801: read at +1, write at +2, done at +3
    issue(3'b001, 12'h801, 5'd5, 32'h1234_5678);
    chk("rw_re", {31'b0, bus.read_enable_csr}, 32'h1);
    chk("rw_ridx", {20'b0, bus.csr_read_index}, 32'h801);
    chk("rw_busy", {31'b0, bus.busy}, 32'h1);
    chk("rw_we_early", {31'b0, bus.write_enable_csr}, 32'h0);
    step();
    chk("rw_we", {31'b0, bus.write_enable_csr}, 32'h1);
    chk("rw_widx", {20'b0, bus.csr_write_index}, 32'h801);
    chk("rw_wdata", bus.csr_write_data, 32'h1234_5678);
    chk("rw_re_off", {31'b0, bus.read_enable_csr}, 32'h0);
    step();
    chk("rw_done", {31'b0, bus.done}, 32'h1);
    chk("rw_rd", bus.rd_data, 32'h0000_00AA);
    chk("rw_illegal", {31'b0, bus.illegal}, 32'h0);
    chk("rw_mul", mul_csr, 32'h1234_5678);
    step();
    chk("rw_idle_done", {31'b0, bus.done}, 32'h0);
    chk("rw_idle_busy", {31'b0, bus.busy}, 32'h0);
    chk("rw_idle_widx", {20'b0, bus.csr_write_index}, 32'h0);

    // RSI then RCI on 0x800
    issue(3'b110, 12'h800, 5'h0F, 32'hFFFF_FFFF);
    step();
    chk("rsi_wdata", bus.csr_write_data, 32'h0000_00FF);
    step();
    chk("rsi_rd", bus.rd_data, 32'h0000_00F0);
    step();
    issue(3'b111, 12'h800, 5'h03, 32'hFFFF_FFFF);
    step();
    chk("rci_wdata", bus.csr_write_data, 32'h0000_00FC);
    step();
    chk("rci_done", {31'b0, bus.done}, 32'h1);
    chk("rci_rd", bus.rd_data, 32'h0000_00FF);
    chk("rci_alu", alu_csr, 32'h0000_00FC);
    step();

    // RS with rs1=0: no write, done at +2
    we0 = we_cnt;
    issue(3'b010, 12'h802, 5'd0, 32'hFFFF_0000);
    chk("sup_re", {31'b0, bus.read_enable_csr}, 32'h1);
    step();
    chk("sup_done", {31'b0, bus.done}, 32'h1);
    chk("sup_rd", bus.rd_data, 32'h0000_0055);
    chk("sup_we", {31'b0, bus.write_enable_csr}, 32'h0);
    step();
    chk("sup_we_cnt", we_cnt - we0, 32'h0);
    chk("sup_div", div_csr, 32'h0000_0055);

    // Illegal index, then illegal opcode: done at +1, no strobes
    we0 = we_cnt; re0 = re_cnt;
    issue(3'b001, 12'h300, 5'd1, 32'h1);
    chk("ill1_done", {31'b0, bus.done}, 32'h1);
    chk("ill1_flag", {31'b0, bus.illegal}, 32'h1);
    chk("ill1_rd", bus.rd_data, 32'h0);
    step();
    chk("ill1_clr", {31'b0, bus.illegal}, 32'h0);
    issue(3'b100, 12'h800, 5'd1, 32'h1);
    chk("ill2_done", {31'b0, bus.done}, 32'h1);
    chk("ill2_flag", {31'b0, bus.illegal}, 32'h1);
    chk("ill2_rd", bus.rd_data, 32'h0);
    step();
    chk("ill_strobes", (we_cnt - we0) + (re_cnt - re0), 32'h0);

    // Reset asserted in WRITE before the falling edge
    issue(3'b001, 12'h801, 5'd1, 32'hDEAD_BEEF);
    step();
    chk("rst_mid_we_pre", {31'b0, bus.write_enable_csr}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_we", {31'b0, bus.write_enable_csr}, 32'h0);
    chk("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_mid_wdata", bus.csr_write_data, 32'h0);
    @(negedge CLK); #1;
    chk("rst_mid_mul", mul_csr, 32'h1234_5678);
    reset = 1'b1;
    issue(3'b001, 12'h801, 5'd1, 32'hCAFE_F00D);
    chk("rst_rel_re", {31'b0, bus.read_enable_csr}, 32'h1);
    step(); step();
    chk("rst_rel_done", {31'b0, bus.done}, 32'h1);
    chk("rst_rel_rd", bus.rd_data, 32'h1234_5678);
    chk("rst_rel_mul", mul_csr, 32'hCAFE_F00D);
    step();

    // start held high through READ..DONE is ignored; one done pulse only
    d0 = done_cnt;
    issue(3'b001, 12'h802, 5'd1, 32'h1111_1111);
    bus.start = 1'b1; bus.csr_index = 12'h800; bus.rs1_data = 32'h2222_2222;
    step();
    chk("busy_widx", {20'b0, bus.csr_write_index}, 32'h802);
    chk("busy_wdata", bus.csr_write_data, 32'h1111_1111);
    step();
    chk("busy_done", {31'b0, bus.done}, 32'h1);
    chk("busy_rd", bus.rd_data, 32'h0000_0055);
    step();
    bus.start = 1'b0;
    chk("busy_idle", {31'b0, bus.busy}, 32'h0);
    step(); step();
    chk("busy_idle2", {31'b0, bus.busy}, 32'h0);
    chk("busy_done_cnt", done_cnt - d0, 32'h1);
    chk("busy_alu", alu_csr, 32'h0000_00FC);
    chk("busy_div", div_csr, 32'h1111_1111);
    chk("no_overlap", overlap_cnt, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
